// File: rtl/pcie_wr_dma.sv
// pcie_wr_dma
// FPGA-to-host DMA write engine. It drains a first-word-fall-through FIFO in
// bursts of 16 x 64-bit words, which is one 128-byte memory write. Each burst
// goes to the next 128 B block of a host ring buffer. The ring is described by
// a page table of 4 KiB pages that the host loads.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   enable              allows new bursts; a burst in progress always completes
//   ptr_clear           zeroes hw_ptr (honoured only while idle)
//   pt_we/pt_index/pt_data  page-table write port (address bits [11:0] dropped)
//   sw_ptr              host consumed pointer, in 128 B blocks
//   hw_ptr              blocks written, in 128 B blocks
//   fifo_data/fifo_ge16/fifo_read  FWFT FIFO head word, >=16 flag, pop strobe
//   wr_valid/wr_addr/wr_ready/wr_data  write-request handshake to the TX block
module pcie_wr_dma #(
   parameter int PT_BITS = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               ptr_clear,
   input  logic               pt_we,
   input  logic [PT_BITS-1:0] pt_index,
   input  logic [63:0]        pt_data,
   input  logic [31:0]        sw_ptr,
   output logic [31:0]        hw_ptr,
   input  logic [63:0]        fifo_data,
   input  logic               fifo_ge16,
   output logic               fifo_read,
   output logic               wr_valid,
   output logic [63:0]        wr_addr,
   input  logic               wr_ready,
   output logic [63:0]        wr_data
);

   localparam int          BLK_BITS    = PT_BITS + 5;
   localparam logic [31:0] RING_BLOCKS = 32'd1 << BLK_BITS;

   typedef enum logic [1:0] {IDLE, ARMED, BURST, SETTLE} state_t;

   state_t              state_reg;
   logic [31:0]         hw_ptr_reg;
   logic                wr_valid_reg;
   logic [63:0]         wr_addr_reg;
   logic [3:0]          beat_reg;
   logic                settle_reg;
   logic                protocol_error_reg;

   // Page table. Entries hold 4 KiB-aligned page addresses. The low 12 bits
   // are cleared on write, so the entry can be ORed with the block offset.
   logic [63:0]         pt_mem [0:(2**PT_BITS)-1];

   logic [31:0]         used_next;
   logic                ring_full_next;
   logic [BLK_BITS-1:0] blk_next;
   logic [63:0]         pt_entry_next;

   // The TX block takes one word per wr_ready, so the FIFO pops in lockstep.
   assign fifo_read = wr_ready;
   assign wr_data   = fifo_data;
   assign hw_ptr    = hw_ptr_reg;
   assign wr_valid  = wr_valid_reg;
   assign wr_addr   = wr_addr_reg;

   always_comb begin
      used_next      = hw_ptr_reg - sw_ptr;
      // A used count beyond the ring size can only come from a bogus sw_ptr.
      // Treating it as full keeps the engine from overwriting live data.
      ring_full_next = (used_next >= RING_BLOCKS);
      blk_next       = hw_ptr_reg[BLK_BITS-1:0];
      pt_entry_next  = pt_mem[blk_next[BLK_BITS-1:5]];
   end

   // A write in the same cycle as an address compute lands after the read.
   // The arm in that cycle therefore still sees the old entry.
   always_ff @(posedge clock) begin
      if (pt_we)
         pt_mem[pt_index] <= pt_data & ~64'hFFF;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg          <= IDLE;
         hw_ptr_reg         <= '0;
         wr_valid_reg       <= 1'b0;
         wr_addr_reg        <= '0;
         beat_reg           <= '0;
         settle_reg         <= 1'b0;
         protocol_error_reg <= 1'b0;
      end else begin
         // wr_ready outside a request cannot belong to any burst. It is
         // ignored, but the error is remembered.
         if (wr_ready && (state_reg == IDLE || state_reg == SETTLE))
            protocol_error_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (ptr_clear) begin
                  hw_ptr_reg <= '0;
               end else if (enable && fifo_ge16 && !ring_full_next) begin
                  wr_addr_reg <= pt_entry_next | {52'd0, blk_next[4:0], 7'd0};
                  state_reg   <= ARMED;
               end
            end
            ARMED: begin
               // wr_valid rises one cycle after entry. The address is then
               // settled, and back-to-back bursts get their idle gap.
               if (wr_ready) begin
                  wr_valid_reg <= 1'b0;
                  beat_reg     <= 4'd1;
                  state_reg    <= BURST;
               end else if (!enable) begin
                  wr_valid_reg <= 1'b0;
                  state_reg    <= IDLE;
               end else begin
                  wr_valid_reg <= 1'b1;
               end
            end
            BURST: begin
               if (wr_ready) begin
                  if (beat_reg == 4'd15) begin
                     hw_ptr_reg <= hw_ptr_reg + 32'd1;
                     beat_reg   <= '0;
                     settle_reg <= 1'b0;
                     state_reg  <= SETTLE;
                  end else begin
                     beat_reg <= beat_reg + 4'd1;
                  end
               end
            end
            SETTLE: begin
               // The two-cycle wait lets fifo_ge16 and sw_ptr catch up with
               // the pops and the pointer advance before the next decision.
               if (settle_reg)
                  state_reg <= IDLE;
               else
                  settle_reg <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   a_no_protocol_error: assert property (@(posedge clock) disable iff (reset)
      !protocol_error_reg);

endmodule

// File: tb/tb_pcie_wr_dma.sv
// Testbench for pcie_wr_dma. The stimulus pushes expected addresses and data
// words into queues. A negedge monitor pops and compares them whenever the DUT
// raises wr_valid or pops the FIFO.
module tb_pcie_wr_dma;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        ptr_clear = 1'b0;
   logic        pt_we = 1'b0;
   logic [4:0]  pt_index = '0;
   logic [63:0] pt_data = '0;
   logic [31:0] sw_ptr = '0;
   logic [31:0] hw_ptr;
   logic [63:0] fifo_data;
   logic        fifo_ge16 = 1'b0;
   logic        fifo_read;
   logic        wr_valid;
   logic [63:0] wr_addr;
   logic        wr_ready = 1'b0;
   logic [63:0] wr_data;

   int          checks = 0;
   int          failures = 0;
   int          pop_count = 0;
   logic [63:0] fifo_word = '0;
   logic [63:0] exp_next_word = '0;
   logic [63:0] cur_addr = '0;
   logic        prev_valid = 1'b0;
   logic [63:0] exp_addr_q[$];
   logic [63:0] exp_data_q[$];

   pcie_wr_dma #(.PT_BITS(5)) dut (
      .clock(clock), .reset(reset), .enable(enable), .ptr_clear(ptr_clear),
      .pt_we(pt_we), .pt_index(pt_index), .pt_data(pt_data), .sw_ptr(sw_ptr),
      .hw_ptr(hw_ptr), .fifo_data(fifo_data), .fifo_ge16(fifo_ge16),
      .fifo_read(fifo_read), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_ready(wr_ready), .wr_data(wr_data)
   );

   always #5 clock = ~clock;

   // FWFT FIFO model: the head word is a running count that advances on each pop.
   assign fifo_data = fifo_word;
   always @(posedge clock) if (fifo_read) fifo_word <= fifo_word + 64'd1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clock) begin
      if (!reset) begin
         if (wr_valid && !prev_valid) begin
            if (exp_addr_q.size() == 0) begin
               check("unexpected_wr_valid", 64'd1, 64'd0);
            end else begin
               cur_addr = exp_addr_q.pop_front();
               check("wr_addr", wr_addr, cur_addr);
            end
         end
         if (fifo_read) begin
            pop_count++;
            if (exp_data_q.size() == 0) begin
               check("unexpected_fifo_read", 64'd1, 64'd0);
            end else begin
               check("wr_data", wr_data, exp_data_q.pop_front());
            end
            check("wr_addr_stable", wr_addr, cur_addr);
         end
      end
      prev_valid = wr_valid;
   end

   task automatic expect_burst(input logic [63:0] addr, input int nwords);
      exp_addr_q.push_back(addr);
      for (int w = 0; w < nwords; w++) begin
         exp_data_q.push_back(exp_next_word);
         exp_next_word = exp_next_word + 64'd1;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic write_pt(input int idx, input logic [63:0] data);
      pt_we = 1'b1;
      pt_index = 5'(idx);
      pt_data = data;
      step(1);
      pt_we = 1'b0;
   endtask

   // Acts as the TX block for one burst: waits for wr_valid, then gives 16
   // wr_ready pulses. Options: fixed gaps, enable drop after a given pulse,
   // and a reset after a given pulse.
   task automatic do_burst(input int gapped, input int drop_after, input int reset_after);
      logic found;
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (wr_valid) begin
            found = 1'b1;
            break;
         end
         step(1);
      end
      check("burst_start_timeout", 64'(found), 64'd1);
      if (found) begin
         for (int i = 1; i <= 16; i++) begin
            wr_ready = 1'b1;
            step(1);
            wr_ready = 1'b0;
            if (i == 1) check("wr_valid_after_first_ready", 64'(wr_valid), 64'd0);
            if (i == drop_after) enable = 1'b0;
            if (i == reset_after) begin
               reset = 1'b1;
               step(1);
               check("reset_wr_valid", 64'(wr_valid), 64'd0);
               check("reset_hw_ptr", 64'(hw_ptr), 64'd0);
               reset = 1'b0;
               break;
            end
            if (gapped != 0) step((i * 7) % 4);
         end
      end
   endtask

   task automatic watch_no_valid(input string name, input int n);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < n; c++) begin
         step(1);
         if (wr_valid) seen = 1'b1;
      end
      check(name, 64'(seen), 64'd0);
   endtask

   function automatic logic [63:0] ring_addr(input int unsigned blk);
      return 64'h40_0000_0000 + (64'((blk >> 5) % 32) << 16) + 64'((blk % 32) * 128);
   endfunction

   initial begin
      int pops0;
      // Reset state
      step(3);
      check("rst_wr_valid", 64'(wr_valid), 64'd0);
      check("rst_fifo_read", 64'(fifo_read), 64'd0);
      check("rst_hw_ptr", 64'(hw_ptr), 64'd0);
      reset = 1'b0;
      step(1);

      // Single burst
      write_pt(0, 64'h1_2345_6000);
      fifo_ge16 = 1'b1;
      expect_burst(64'h1_2345_6000, 16);
      pops0 = pop_count;
      enable = 1'b1;
      do_burst(0, 16, 0);
      step(5);
      check("single_hw_ptr", 64'(hw_ptr), 64'd1);
      check("single_pops", 64'(pop_count - pops0), 64'd16);

      // Page crossing
      ptr_clear = 1'b1;
      step(1);
      ptr_clear = 1'b0;
      check("clear_hw_ptr", 64'(hw_ptr), 64'd0);
      write_pt(0, 64'h1000);
      write_pt(1, 64'h8ABC);
      enable = 1'b1;
      for (int k = 0; k < 33; k++) begin
         if (k < 32) expect_burst(64'h1000 + 64'(k * 128), 16);
         else expect_burst(64'h8000, 16);
         do_burst(0, (k == 32) ? 16 : 0, 0);
      end
      step(5);
      check("cross_hw_ptr", 64'(hw_ptr), 64'd33);

      // Ring full
      ptr_clear = 1'b1;
      step(1);
      ptr_clear = 1'b0;
      for (int p = 0; p < 32; p++) write_pt(p, 64'h40_0000_0000 + (64'(p) << 16) + 64'hABC);
      sw_ptr = 32'd0;
      enable = 1'b1;
      for (int k = 0; k < 1024; k++) begin
         expect_burst(ring_addr(k), 16);
         do_burst(0, 0, 0);
      end
      watch_no_valid("ring_full_no_valid", 40);
      check("ring_full_hw_ptr", 64'(hw_ptr), 64'd1024);
      expect_burst(ring_addr(1024), 16);
      sw_ptr = 32'd1;
      do_burst(0, 0, 0);
      watch_no_valid("ring_refull_no_valid", 40);
      check("ring_refull_hw_ptr", 64'(hw_ptr), 64'd1025);
      enable = 1'b0;
      step(2);

      // FIFO starvation
      fifo_ge16 = 1'b0;
      sw_ptr = 32'd1025;
      enable = 1'b1;
      watch_no_valid("starve_no_valid", 30);
      expect_burst(ring_addr(1025), 16);
      fifo_ge16 = 1'b1;
      begin
         logic got;
         got = 1'b0;
         for (int c = 0; c < 2; c++) begin
            step(1);
            if (wr_valid) got = 1'b1;
         end
         check("starve_valid_within_2", 64'(got), 64'd1);
      end
      do_burst(0, 16, 0);
      step(5);
      check("starve_hw_ptr", 64'(hw_ptr), 64'd1026);

      // Gapped wr_ready, enable drops after pulse 5
      enable = 1'b1;
      expect_burst(ring_addr(1026), 16);
      pops0 = pop_count;
      do_burst(1, 5, 0);
      watch_no_valid("gap_no_new_valid", 30);
      check("gap_hw_ptr", 64'(hw_ptr), 64'd1027);
      check("gap_pops", 64'(pop_count - pops0), 64'd16);

      // Reset after 8 pulses
      enable = 1'b1;
      expect_burst(ring_addr(1027), 8);
      do_burst(0, 0, 8);
      enable = 1'b0;
      sw_ptr = 32'd0;
      step(3);

      // Seven bursts, then ptr_clear in IDLE with hw_ptr = 7
      enable = 1'b1;
      for (int k = 0; k < 7; k++) begin
         expect_burst(ring_addr(k), 16);
         do_burst(0, (k == 6) ? 16 : 0, 0);
      end
      step(6);
      check("pre_clear_hw_ptr", 64'(hw_ptr), 64'd7);
      expect_burst(ring_addr(0), 16);
      ptr_clear = 1'b1;
      enable = 1'b1;
      step(1);
      ptr_clear = 1'b0;
      check("ptr_clear_hw_ptr", 64'(hw_ptr), 64'd0);
      step(1);
      check("ptr_clear_no_arm", 64'(wr_valid), 64'd0);
      do_burst(0, 16, 0);
      step(6);
      check("post_clear_hw_ptr", 64'(hw_ptr), 64'd1);

      check("leftover_addr_expect", 64'(exp_addr_q.size()), 64'd0);
      check("leftover_data_expect", 64'(exp_data_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
